// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width derivation and Gray/binary conversion.
// Used by both the read-side and write-side pointer stages.
package fifo_pkg;

    localparam int FN_W = 32;

    function automatic int addr_w_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_w_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Callers zero-extend into FN_W bits and cast the result back to their pointer width.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rdptr_empty_if.sv
// Read-side bus of the async FIFO: consumer handshake, memory address and pointer exchange.
interface fifo_rdptr_empty_if
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam int PTR_W  = ptr_w_of(DEPTH);

    logic              R_INC;
    logic [PTR_W-1:0]  gray_Wptr;
    logic              REMPTY;
    logic              R_AEMPTY;
    logic [PTR_W-1:0]  R_LEVEL;
    logic [ADDR_W-1:0] Raddr;
    logic [PTR_W-1:0]  gray_Rptr;

    modport master (
        output R_INC,
        output gray_Wptr,
        input  REMPTY,
        input  R_AEMPTY,
        input  R_LEVEL,
        input  Raddr,
        input  gray_Rptr
    );

    modport slave (
        input  R_INC,
        input  gray_Wptr,
        output REMPTY,
        output R_AEMPTY,
        output R_LEVEL,
        output Raddr,
        output gray_Rptr
    );
endinterface

// File: rtl/fifo_df_sync.sv
// Two-flop synchroniser for a Gray-coded bus; only sync_meta_q may go metastable.
module fifo_df_sync #(
    parameter int BUS_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] d_i,
    output logic [BUS_WIDTH-1:0] q_o
);
    logic [BUS_WIDTH-1:0] sync_meta_q;
    logic [BUS_WIDTH-1:0] sync_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= '0;
            sync_out_q  <= '0;
        end else begin
            sync_meta_q <= d_i;
            sync_out_q  <= sync_meta_q;
        end
    end

    assign q_o = sync_out_q;
endmodule

// File: rtl/fifo_rdptr_empty.sv
// Read-domain pointer, registered empty flag, fill level and almost-empty for the async FIFO.
module fifo_rdptr_empty
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AE_THRESH = 2
) (
    input  logic              R_CLK,
    input  logic              R_RST,
    fifo_rdptr_empty_if.slave bus
);
    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam int PTR_W  = ptr_w_of(DEPTH);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] gray_rptr_q, gray_rptr_d;
    logic             rempty_q, rempty_d;
    logic             rd_accept;
    logic [PTR_W-1:0] wq2_gray;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] level;

    fifo_df_sync #(
        .BUS_WIDTH(PTR_W)
    ) u_wptr_sync (
        .clk  (R_CLK),
        .rst_n(R_RST),
        .d_i  (bus.gray_Wptr),
        .q_o  (wq2_gray)
    );

    // Empty compares the post-read pointer against the synchronised write pointer,
    // so the flag asserts on the same edge that pops the last word.
    always_comb begin
        rd_accept   = bus.R_INC && !rempty_q;
        rptr_d      = rptr_q + PTR_W'(rd_accept);
        gray_rptr_d = PTR_W'(bin2gray(FN_W'(rptr_d)));
        rempty_d    = (gray_rptr_d == wq2_gray);
        wbin        = PTR_W'(gray2bin(FN_W'(wq2_gray)));
        level       = wbin - rptr_q;
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rptr_q      <= '0;
            gray_rptr_q <= '0;
            rempty_q    <= 1'b1;
        end else begin
            rptr_q      <= rptr_d;
            gray_rptr_q <= gray_rptr_d;
            rempty_q    <= rempty_d;
        end
    end

    assign bus.Raddr     = rptr_q[ADDR_W-1:0];
    assign bus.gray_Rptr = gray_rptr_q;
    assign bus.REMPTY    = rempty_q;
    assign bus.R_LEVEL   = level;
    assign bus.R_AEMPTY  = (level <= PTR_W'(AE_THRESH));
endmodule
